// File: rtl/adder_tree_pkg.sv
// Shared types and constants for the adder tree feeder and its tree.
// Latency: none (declarations only).
// Backpressure: not applicable.
package adder_tree_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    FILL,
    WAIT,
    HOLD
  } feeder_state_t;

  // Width of an n-input sum of SAMPLE_W-bit samples: one growth bit per tree level.
  function automatic int sum_width(input int n);
    return SAMPLE_W + $clog2(n);
  endfunction

endpackage

// File: rtl/adder_tree_feeder.sv
// Gathers N serial samples into the tree's stage_zero vector and returns one sum per frame.
// Latency: sum captured L+1 edges after the last sample is accepted; sum_valid follows.
// Backpressure: in_ready low from frame completion until the cycle after the sum handshake.
module adder_tree_feeder
  import adder_tree_pkg::*;
#(
  parameter int N = 4,
  parameter int L = $clog2(N),
  parameter int W = SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N-1:0][W-1:0]   stage_zero,
  input  logic [W+L-1:0]        tree_result,
  output logic [W+L-1:0]        sum_out,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  input  logic                  flush
);

  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int WCNT_W = (L > 0) ? $clog2(L + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(L);

  feeder_state_t      state;
  feeder_state_t      state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WCNT_W-1:0]  wcnt;
  logic               accept;
  logic               wait_done;

  // A handshake during flush is still a handshake on the wire, but flush discards the sample.
  assign accept    = in_valid & in_ready;
  assign wait_done = (wcnt == WCNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and in_ready decode; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && (cnt == CNT_LAST)) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (wait_done) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (sum_ready) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
    if (flush) begin
      state_nxt = FILL;
    end
  end

  // Sample slotting and the pipeline wait counter; stage_zero stays frozen outside FILL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      wcnt       <= '0;
      stage_zero <= '0;
    end else if (flush) begin
      cnt  <= '0;
      wcnt <= '0;
    end else begin
      if (accept) begin
        stage_zero[cnt] <= in_data;
        cnt             <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
      if (state == WAIT) begin
        wcnt <= wait_done ? '0 : wcnt + 1'b1;
      end else begin
        wcnt <= '0;
      end
    end
  end

  // Result capture once the tree has had L cycles, held until the consumer takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else if (flush) begin
      sum_valid <= 1'b0;
    end else if ((state == WAIT) && wait_done) begin
      sum_out   <= tree_result;
      sum_valid <= 1'b1;
    end else if ((state == HOLD) && sum_ready) begin
      sum_valid <= 1'b0;
    end
  end

endmodule
